// File: rtl/screen_mirror_reader_pkg.sv
// Shared types and constants for the screen mirror reader.
// Optional build macro: SCREEN_MIRROR_CLEAR_EN (framebuffer clear sweep after reset).
package screen_mirror_reader_pkg;

  localparam logic [14:0] SCREEN_BASE    = 15'd16384;
  localparam int unsigned WORDS_PER_LINE = 32;
  localparam int unsigned LINES          = 256;
  localparam int unsigned FB_WORDS       = WORDS_PER_LINE * LINES;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SHIFT
  } t_scan_state;

endpackage

// File: rtl/screen_mirror_reader_if.sv
// CPU snoop inputs and pixel stream handshake of the screen mirror reader.
// ClrBusy exists only when SCREEN_MIRROR_CLEAR_EN is defined.
interface screen_mirror_reader_if;

  logic        WrEnM;
  logic [14:0] WrAddrM;
  logic [15:0] WrDataM;
  logic        ScanEn;
  logic        PixelReady;
  logic        PixelValid;
  logic        Pixel;
  logic [8:0]  PixelX;
  logic [7:0]  PixelY;
  logic        FrameStart;
  logic        LineEnd;
  logic        SnoopHit;
`ifdef SCREEN_MIRROR_CLEAR_EN
  logic        ClrBusy;
`endif

  modport master (
    output WrEnM, WrAddrM, WrDataM, ScanEn, PixelReady,
    input  PixelValid, Pixel, PixelX, PixelY, FrameStart, LineEnd, SnoopHit
`ifdef SCREEN_MIRROR_CLEAR_EN
    , input ClrBusy
`endif
  );

  modport slave (
    input  WrEnM, WrAddrM, WrDataM, ScanEn, PixelReady,
    output PixelValid, Pixel, PixelX, PixelY, FrameStart, LineEnd, SnoopHit
`ifdef SCREEN_MIRROR_CLEAR_EN
    , output ClrBusy
`endif
  );

endinterface

// File: rtl/mirror_fb_ram.sv
// 1W/1R synchronous framebuffer RAM, one-cycle read latency.
// A read of the address being written in the same cycle returns the new data.
module mirror_fb_ram #(
  parameter int unsigned DEPTH = 8192,
  parameter int unsigned AW    = 13,
  parameter int unsigned DW    = 16
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  localparam int unsigned IW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;
  logic [IW-1:0] w_wa;
  logic [IW-1:0] w_ra;

  assign w_wa    = i_waddr[IW-1:0];
  assign w_ra    = i_raddr[IW-1:0];
  assign o_rdata = r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[w_wa] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[w_ra];
    end
  end

endmodule

// File: rtl/screen_mirror_reader.sv
// Snoops CPU writes into a private screen framebuffer and scans it out as a raster pixel stream.
// Optional build macro: SCREEN_MIRROR_CLEAR_EN adds a post-reset clear sweep and the ClrBusy output.
module screen_mirror_reader
  import screen_mirror_reader_pkg::*;
#(
  parameter logic [14:0] P_SCREEN_BASE = SCREEN_BASE,
  parameter int unsigned P_LINES       = LINES
) (
  input logic                   Clk,
  input logic                   Reset,
  screen_mirror_reader_if.slave bus
);

  localparam int unsigned L_WORDS     = WORDS_PER_LINE * P_LINES;
  localparam logic [14:0] L_FB_WORDS  = 15'(L_WORDS);
  localparam logic [12:0] L_LAST_WORD = 13'(L_WORDS - 1);

  // Snoop decode: offset compare also rejects addresses below the base via the lower-bound term
  logic [14:0] w_off;
  logic        w_hit;
  logic        r_snoop_hit;

  assign w_off = bus.WrAddrM - P_SCREEN_BASE;
  assign w_hit = bus.WrEnM && (bus.WrAddrM >= P_SCREEN_BASE) && (w_off < L_FB_WORDS);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_snoop_hit <= 1'b0;
    end else begin
      r_snoop_hit <= w_hit;
    end
  end

  logic        w_we;
  logic [12:0] w_waddr;
  logic [15:0] w_wdata;
  logic        w_scan_ok;

`ifdef SCREEN_MIRROR_CLEAR_EN
  logic        r_clr_busy;
  logic [12:0] r_clr_ptr;

  // Snoop writes own port A; the sweep pointer stalls on those cycles
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_clr_busy <= 1'b1;
      r_clr_ptr  <= '0;
    end else if (r_clr_busy && !w_hit) begin
      r_clr_ptr <= r_clr_ptr + 13'd1;
      if (r_clr_ptr == L_LAST_WORD) begin
        r_clr_busy <= 1'b0;
      end
    end
  end

  always_comb begin
    w_we    = w_hit || r_clr_busy;
    w_waddr = w_hit ? w_off[12:0] : r_clr_ptr;
    w_wdata = w_hit ? bus.WrDataM : '0;
  end

  assign bus.ClrBusy = r_clr_busy;
  assign w_scan_ok   = !r_clr_busy;
`else
  assign w_we      = w_hit;
  assign w_waddr   = w_off[12:0];
  assign w_wdata   = bus.WrDataM;
  assign w_scan_ok = 1'b1;
`endif

  t_scan_state r_state,    w_state_nxt;
  logic [12:0] r_word_ptr, w_word_ptr_nxt;
  logic [3:0]  r_bit_idx,  w_bit_idx_nxt;
  logic [15:0] r_shift,    w_shift_nxt;
  logic        w_re;
  logic [15:0] w_rdata;

  mirror_fb_ram #(
    .DEPTH (L_WORDS),
    .AW    (13),
    .DW    (16)
  ) u_fb (
    .i_clk   (Clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (r_word_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_word_ptr <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_word_ptr <= w_word_ptr_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_shift    <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_word_ptr_nxt = r_word_ptr;
    w_bit_idx_nxt  = r_bit_idx;
    w_shift_nxt    = r_shift;
    w_re           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.ScanEn && w_scan_ok) begin
          w_state_nxt    = S_FETCH;
          w_word_ptr_nxt = '0;
        end
      end
      S_FETCH: begin
        w_re        = 1'b1;
        w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_shift_nxt   = w_rdata;
        w_bit_idx_nxt = '0;
        w_state_nxt   = S_SHIFT;
      end
      S_SHIFT: begin
        if (bus.PixelReady) begin
          w_bit_idx_nxt = r_bit_idx + 4'd1;
          if (r_bit_idx == 4'd15) begin
            if (r_word_ptr == L_LAST_WORD) begin
              w_state_nxt    = S_IDLE;
              w_word_ptr_nxt = '0;
            end else begin
              w_state_nxt    = S_FETCH;
              w_word_ptr_nxt = r_word_ptr + 13'd1;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  logic w_valid;

  assign w_valid        = (r_state == S_SHIFT);
  assign bus.PixelValid = w_valid;
  assign bus.Pixel      = w_valid & r_shift[r_bit_idx];
  assign bus.PixelX     = w_valid ? {r_word_ptr[4:0], r_bit_idx} : '0;
  assign bus.PixelY     = w_valid ? r_word_ptr[12:5] : '0;
  assign bus.FrameStart = w_valid && (r_word_ptr == '0) && (r_bit_idx == '0);
  assign bus.LineEnd    = w_valid && (r_word_ptr[4:0] == 5'd31) && (r_bit_idx == 4'd15);
  assign bus.SnoopHit   = r_snoop_hit;

endmodule

// File: tb/tb_screen_mirror_reader.sv
// Randomized self-checking bench for screen_mirror_reader, run on a reduced 8-line frame.
// Optional build macro: SCREEN_MIRROR_CLEAR_EN (bench then also models the clear sweep).
module tb_screen_mirror_reader;
  import screen_mirror_reader_pkg::*;

  localparam int unsigned TB_LINES = 8;
  localparam int unsigned W        = WORDS_PER_LINE * TB_LINES;
  localparam int unsigned NPIX     = 16 * W;
  localparam int unsigned BASE     = 16384;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  screen_mirror_reader_if bus();

  screen_mirror_reader #(.P_LINES(TB_LINES)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  logic [15:0] mdl_mem [W];
  int unsigned pos;
  int unsigned frames_done;
  bit          frame_active;
  bit          rand_ready;
  int unsigned n_checks;
  int unsigned n_pass;
  int unsigned n_fail;
`ifdef SCREEN_MIRROR_CLEAR_EN
  int unsigned mdl_clr;
`endif

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int unsigned a, input logic [15:0] d);
    bus.WrEnM   = 1'b1;
    bus.WrAddrM = 15'(a);
    bus.WrDataM = d;
    cyc();
    bus.WrEnM   = 1'b0;
  endtask

  task automatic pulse_scan();
    bus.ScanEn   = 1'b1;
    frame_active = 1'b1;
    cyc();
    bus.ScanEn   = 1'b0;
  endtask

  task automatic wait_frame(input int unsigned bound);
    int unsigned start;
    start = frames_done;
    for (int unsigned i = 0; i < bound && frames_done == start; i++) cyc();
    check("frame_complete", frames_done - start, 1);
  endtask

  // Raster rule: pixel index p maps to word p/16 bit p%16, X = p%512, Y = p/512
  function automatic logic [19:0] exp_out(input int unsigned p);
    int unsigned x;
    int unsigned y;
    logic [15:0] wd;
    x  = p % 512;
    y  = p / 512;
    wd = mdl_mem[p / 16];
    return {wd[p % 16], 9'(x), 8'(y), (p == 0), (x == 511)};
  endfunction

  always begin
    @(posedge clk);
    #2;
    bus.PixelReady = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Sampled at +1, before inputs move at +2: inputs visible here are those the last edge used
  initial begin : compare_proc
    logic        prev_valid;
    logic [19:0] prev_out;
    logic [19:0] cur_out;
    int unsigned a;
    bit          hit;
    prev_valid = 1'b0;
    prev_out   = '0;
    forever begin
      @(posedge clk);
      #1;
      cur_out = {bus.Pixel, bus.PixelX, bus.PixelY, bus.FrameStart, bus.LineEnd};
      if (rst) begin
        pos          = 0;
        frame_active = 1'b0;
        prev_valid   = 1'b0;
`ifdef SCREEN_MIRROR_CLEAR_EN
        mdl_clr = 0;
`endif
        check("snoop_in_reset", bus.SnoopHit, 0);
        continue;
      end
      a   = int'(bus.WrAddrM);
      hit = bus.WrEnM && a >= BASE && a < BASE + W;
      check("snoop_hit", bus.SnoopHit, hit);
      if (hit) mdl_mem[a - BASE] = bus.WrDataM;
`ifdef SCREEN_MIRROR_CLEAR_EN
      else if (mdl_clr < W) begin
        mdl_mem[mdl_clr] = '0;
        mdl_clr++;
      end
      check("clr_busy", bus.ClrBusy, (mdl_clr < W));
`endif
      if (prev_valid && bus.PixelReady) begin
        pos++;
        if (pos == NPIX) begin
          pos          = 0;
          frame_active = 1'b0;
          frames_done++;
        end
      end else if (prev_valid) begin
        check("hold_stable", {bus.PixelValid, cur_out}, {1'b1, prev_out});
      end
      if (bus.PixelValid) begin
        if (!frame_active) check("valid_outside_frame", bus.PixelValid, 0);
        else check("pixel", cur_out, exp_out(pos));
      end
      prev_valid = bus.PixelValid;
      prev_out   = cur_out;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int unsigned first;
    int unsigned last;
    bit          found;
    logic [15:0] got_word;
    int unsigned collected;

    n_checks = 0; n_pass = 0; n_fail = 0;
    pos = 0; frames_done = 0; frame_active = 1'b0; rand_ready = 1'b0;
    for (int unsigned i = 0; i < W; i++) mdl_mem[i] = '0;
    rst            = 1'b1;
    bus.WrEnM      = 1'b0;
    bus.WrAddrM    = '0;
    bus.WrDataM    = '0;
    bus.ScanEn     = 1'b0;
    bus.PixelReady = 1'b1;
    repeat (3) cyc();
    check("reset_valid", bus.PixelValid, 0);
    check("reset_outs", {bus.Pixel, bus.PixelX, bus.PixelY, bus.FrameStart, bus.LineEnd, bus.SnoopHit}, 0);
    rst = 1'b0;
`ifdef SCREEN_MIRROR_CLEAR_EN
    for (int unsigned i = 0; i < W + 20 && bus.ClrBusy; i++) cyc();
    check("clr_done_after_reset", bus.ClrBusy, 0);
`endif

    // Fill every word with random data through the snoop port
    for (int unsigned i = 0; i < W; i++) wr(BASE + i, 16'($urandom));

    wr(BASE - 1, 16'hFFFF);
    check("snoop_below_base", bus.SnoopHit, 0);
    wr(BASE + W, 16'hFFFF);
    check("snoop_above_top", bus.SnoopHit, 0);
    wr(24576, 16'hFFFF);
    wr(0, 16'hFFFF);
    wr(BASE, 16'h8001);
    check("snoop_at_base", bus.SnoopHit, 1);
    wr(BASE + W - 1, 16'hFFFF);
    check("snoop_at_top", bus.SnoopHit, 1);

    // Full frame with PixelReady held high
    first = 0; last = 0;
    bus.ScanEn   = 1'b1;
    frame_active = 1'b1;
    for (int unsigned i = 1; i <= 18 * W + 8; i++) begin
      cyc();
      if (i == 1) bus.ScanEn = 1'b0;
      if (bus.PixelValid) begin
        if (first == 0) first = i;
        last = i;
        if (bus.PixelY == 0 && bus.PixelX == 0) check("px_origin", {bus.Pixel, bus.FrameStart}, 2'b11);
        if (bus.PixelY == 0 && bus.PixelX >= 1 && bus.PixelX <= 14) check("px_mid_word0", bus.Pixel, 0);
        if (bus.PixelY == 0 && bus.PixelX == 15) check("px15_word0", bus.Pixel, 1);
        if (bus.PixelY == 8'(TB_LINES - 1) && bus.PixelX == 511)
          check("last_pixel_lineend", {bus.Pixel, bus.LineEnd}, 2'b11);
      end
    end
    check("first_pixel_latency", first, 3);
    check("frame_cycles", last, 18 * W);
    check("idle_after_frame", bus.PixelValid, 0);

    // Random data updates then a frame under random back-pressure
    for (int unsigned i = 0; i < 32; i++) wr(BASE + $urandom_range(0, W - 1), 16'($urandom));
    rand_ready = 1'b1;
    pulse_scan();
    wait_frame(40 * W);
    rand_ready = 1'b0;
    repeat (4) cyc();

    // Reset mid-line, then restart from the origin
    pulse_scan();
    found = 1'b0;
    for (int unsigned i = 0; i < 18 * W && !found; i++) begin
      cyc();
      if (bus.PixelValid && bus.PixelX == 200 && bus.PixelY == 5) found = 1'b1;
    end
    check("reached_200_5", found, 1);
    rst = 1'b1;
    cyc();
    check("midframe_reset_valid", bus.PixelValid, 0);
    check("midframe_reset_outs", {bus.Pixel, bus.PixelX, bus.PixelY, bus.FrameStart, bus.LineEnd}, 0);
    rst = 1'b0;
`ifdef SCREEN_MIRROR_CLEAR_EN
    for (int unsigned c = 0; c < W + 80; c++) begin
      if (c == 1) wr(BASE + 100, 16'h1234);
      else if (c == 60) wr(BASE + 5, 16'h4321);
      else cyc();
      if (c > 60 && !bus.ClrBusy) break;
    end
    check("clr_done_after_midframe_reset", bus.ClrBusy, 0);
`else
    cyc();
`endif
    pulse_scan();
    for (int unsigned i = 0; i < 10 && !bus.PixelValid; i++) cyc();
    check("restart_origin", {bus.PixelValid, bus.PixelX, bus.PixelY, bus.FrameStart}, {1'b1, 18'h1});
    wait_frame(18 * W + 20);
    cyc();

    // Snoop write to word 0 on the same edge its fetch is issued
    wr(BASE, 16'hA5C3);
    cyc();
    bus.ScanEn   = 1'b1;
    frame_active = 1'b1;
    cyc();
    bus.ScanEn  = 1'b0;
    bus.WrEnM   = 1'b1;
    bus.WrAddrM = 15'(BASE);
    bus.WrDataM = 16'h5A3C;
    cyc();
    bus.WrEnM = 1'b0;
    got_word  = '0;
    collected = 0;
    for (int unsigned i = 0; i < 40 && collected < 16; i++) begin
      if (bus.PixelValid && bus.PixelY == 0 && bus.PixelX < 16) begin
        got_word[bus.PixelX[3:0]] = bus.Pixel;
        collected++;
      end
      cyc();
    end
    check("bypass_word", got_word, 16'h5A3C);
    wait_frame(18 * W + 20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
